lmc_core: RTL

- Parametrised multi-cycle accumulator CPU; successor to the fixed 4-bit/16-word LMC datapath.
- Harvard: program RAM (INSTR_W x 2^ADDR_W) plus data RAM (DATA_W x 2^ADDR_W), both loaded/stored on one clock.
- Adds a FETCH/EXEC state machine, HLT, and ready/valid handshakes on input and output in place of free-running buttons.
- Sits between the program loader/switch panel and the display/output register board.

---
 rtl/lmc_pkg.sv | 26 ++
 rtl/lmc_alu.sv | 39 +++
 rtl/lmc_core.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/lmc_pkg.sv
// Shared opcode constants and FSM state type for the LMC accumulator core.
package lmc_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_HLT = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
  localparam logic [OPC_W-1:0] OP_STA = 4'h3;
  localparam logic [OPC_W-1:0] OP_LDA = 4'h5;
  localparam logic [OPC_W-1:0] OP_BRA = 4'h6;
  localparam logic [OPC_W-1:0] OP_BRZ = 4'h7;
  localparam logic [OPC_W-1:0] OP_BRP = 4'h8;
  localparam logic [OPC_W-1:0] OP_INP = 4'h9;
  localparam logic [OPC_W-1:0] OP_OUT = 4'hA;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StWaitIn,
    StWaitOut,
    StHalt
  } lmc_state_t;

endpackage

// File: rtl/lmc_alu.sv
// Combinational add/sub and accumulator flags for lmc_core.
// Define LMC_SAT_ARITH_EN for signed saturating ADD/SUB; default wraps modulo 2^DATA_W.
module lmc_alu #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  input  logic              op_sub,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              pz
);

`ifdef LMC_SAT_ARITH_EN
  logic [DATA_W:0] acc_ext;
  logic [DATA_W:0] opd_ext;
  logic [DATA_W:0] sum_ext;

  always_comb begin
    acc_ext = {acc[DATA_W-1], acc};
    opd_ext = {operand[DATA_W-1], operand};
    sum_ext = op_sub ? (acc_ext - opd_ext) : (acc_ext + opd_ext);
    // Sign-extended top two bits disagree only on signed overflow.
    if (sum_ext[DATA_W] != sum_ext[DATA_W-1]) begin
      result = sum_ext[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      result = sum_ext[DATA_W-1:0];
    end
  end
`else
  always_comb begin
    result = op_sub ? (acc - operand) : (acc + operand);
  end
`endif

  assign z  = (acc == '0);
  assign pz = ~acc[DATA_W-1];

endmodule

// File: rtl/lmc_core.sv
// Multi-cycle Harvard accumulator CPU with FETCH/EXEC sequencing and ready/valid I/O.
// Optional LMC_SAT_ARITH_EN (see lmc_alu) selects saturating ADD/SUB.
module lmc_core
  import lmc_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                    timer555,
  input  logic                    reset_count,
  input  logic                    start,
  input  logic                    prog_we,
  input  logic [ADDR_W-1:0]       prog_addr,
  input  logic [ADDR_W+OPC_W-1:0] prog_data,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       acc_out,
  output logic [ADDR_W-1:0]       pc_out,
  output logic                    z_flag,
  output logic                    pz_flag,
  output logic                    busy,
  output logic                    halted
);

  localparam int unsigned INSTR_W = ADDR_W + OPC_W;
  localparam int unsigned DEPTH   = 2 ** ADDR_W;

  logic [INSTR_W-1:0] prog_mem [DEPTH];
  logic [DATA_W-1:0]  data_mem [DEPTH];

  lmc_state_t         state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] ir_q;
  logic [DATA_W-1:0]  acc_q;
  logic [DATA_W-1:0]  out_data_q;
  logic               out_valid_q;
  logic               in_ready_q;

  logic [OPC_W-1:0]   ir_op;
  logic [ADDR_W-1:0]  ir_addr;
  logic [DATA_W-1:0]  mem_rd;
  logic [DATA_W-1:0]  alu_res;
  logic               z;
  logic               pz;
  logic               stopped;

  assign ir_op   = ir_q[INSTR_W-1 -: OPC_W];
  assign ir_addr = ir_q[ADDR_W-1:0];
  assign mem_rd  = data_mem[ir_addr];
  assign stopped = (state_q == StIdle) || (state_q == StHalt);

  lmc_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .acc     (acc_q),
    .operand (mem_rd),
    .op_sub  (ir_op == OP_SUB),
    .result  (alu_res),
    .z       (z),
    .pz      (pz)
  );

  // RAMs have no reset so contents survive reset_count and restarts.
  always_ff @(posedge timer555) begin
    if (!reset_count && stopped && prog_we) begin
      prog_mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge timer555) begin
    if (!reset_count && (state_q == StExec) && (ir_op == OP_STA)) begin
      data_mem[ir_addr] <= acc_q;
    end
  end

  always_ff @(posedge timer555) begin
    if (reset_count) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      ir_q        <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StHalt: begin
          if (start) begin
            pc_q    <= '0;
            acc_q   <= '0;
            state_q <= StFetch;
          end
        end
        StFetch: begin
          ir_q    <= prog_mem[pc_q];
          pc_q    <= pc_q + 1'b1;
          state_q <= StExec;
        end
        StExec: begin
          state_q <= StFetch;
          case (ir_op)
            OP_HLT:         state_q <= StHalt;
            OP_ADD, OP_SUB: acc_q   <= alu_res;
            OP_LDA:         acc_q   <= mem_rd;
            OP_BRA:         pc_q    <= ir_addr;
            OP_BRZ:         if (z) pc_q <= ir_addr;
            OP_BRP:         if (pz) pc_q <= ir_addr;
            OP_INP: begin
              in_ready_q <= 1'b1;
              state_q    <= StWaitIn;
            end
            OP_OUT: begin
              out_data_q  <= acc_q;
              out_valid_q <= 1'b1;
              state_q     <= StWaitOut;
            end
            default: ;
          endcase
        end
        StWaitIn: begin
          if (in_valid) begin
            acc_q      <= in_data;
            in_ready_q <= 1'b0;
            state_q    <= StFetch;
          end
        end
        StWaitOut: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StFetch;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign acc_out   = acc_q;
  assign pc_out    = pc_q;
  assign z_flag    = z;
  assign pz_flag   = pz;
  assign busy      = (state_q == StFetch) || (state_q == StExec) ||
                     (state_q == StWaitIn) || (state_q == StWaitOut);
  assign halted    = (state_q == StHalt);

endmodule
